// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start bit, DATA_BITS LSB-first, optional parity, 1-2 stop bits.
// Optional clear-to-send gating is compiled in with the UART_TX_CTS_EN macro.
module uart_tx_frame #(
  parameter int CLK_DIV   = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] data,
`ifdef UART_TX_CTS_EN
  input  logic                 cts_n,
`endif
  output logic                 ready,
  output logic                 dout,
  output logic                 done
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("uart_tx_frame: CLK_DIV must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t               state, state_nxt;
  logic [DIV_W-1:0]     div_cnt, div_nxt;
  logic [3:0]           bit_cnt, bit_nxt;
  logic                 dout_r, dout_nxt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 tick, stop_end, cts_ok, accept, shift_en;

`ifdef UART_TX_CTS_EN
  logic [1:0] cts_sync;

  // Synchroniser idles in the "not clear" state so nothing goes out before cts is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cts_sync <= 2'b11;
    else        cts_sync <= {cts_sync[0], cts_n};
  end
  assign cts_ok = ~cts_sync[1];
`else
  assign cts_ok = 1'b1;
`endif

  assign tick     = (div_cnt == DIV_LAST);
  assign stop_end = (state == S_STOP) && tick && (bit_cnt == STOP_LAST);
  // Ready during the final stop cycle lets the next frame start with no idle gap.
  assign ready    = cts_ok && ((state == S_IDLE) || stop_end);
  assign accept   = send && ready;
  assign done     = stop_end;
  assign dout     = dout_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      dout_r  <= 1'b1;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      bit_cnt <= bit_nxt;
      dout_r  <= dout_nxt;
    end
  end

  // Payload and parity are only meaningful after an accept, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg   <= data;
      par_bit <= (^data) ^ (PARITY == 2);
    end else if (shift_en) begin
      shreg   <= shreg >> 1;
    end
  end

  always_comb begin
    state_nxt = state;
    div_nxt   = tick ? '0 : div_cnt + DIV_W'(1);
    bit_nxt   = bit_cnt;
    dout_nxt  = dout_r;
    shift_en  = 1'b0;
    case (state)
      S_IDLE: begin
        div_nxt = '0;
        if (accept) begin
          state_nxt = S_START;
          dout_nxt  = 1'b0;
        end
      end
      S_START: if (tick) begin
        state_nxt = S_DATA;
        bit_nxt   = '0;
        dout_nxt  = shreg[0];
        shift_en  = 1'b1;
      end
      S_DATA: if (tick) begin
        if (bit_cnt != DATA_LAST) begin
          bit_nxt  = bit_cnt + 4'd1;
          dout_nxt = shreg[0];
          shift_en = 1'b1;
        end else if (PARITY != 0) begin
          state_nxt = S_PAR;
          dout_nxt  = par_bit;
        end else begin
          state_nxt = S_STOP;
          bit_nxt   = '0;
          dout_nxt  = 1'b1;
        end
      end
      S_PAR: if (tick) begin
        state_nxt = S_STOP;
        bit_nxt   = '0;
        dout_nxt  = 1'b1;
      end
      S_STOP: if (tick) begin
        if (bit_cnt != STOP_LAST) begin
          bit_nxt = bit_cnt + 4'd1;
        end else if (accept) begin
          state_nxt = S_START;
          dout_nxt  = 1'b0;
        end else begin
          state_nxt = S_IDLE;
          dout_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        dout_nxt  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: two configurations (8N1/16 and 7O2/4) checked cycle by cycle
// against an expected-waveform scoreboard built from each accepted payload.
module tb_uart_tx_frame;

  int cd [2] = '{16, 4};
  int db [2] = '{8, 7};
  int pa [2] = '{0, 2};
  int sb [2] = '{1, 2};

  typedef struct packed {
    logic dout;
    logic done;
    logic ready;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] send_v = 2'b00;
  logic [8:0] data_v [2];
  logic [1:0] dout_v, done_v, ready_v;

  exp_t q [2][$];
  bit   cur_ready [2] = '{1'b1, 1'b1};
  int   acc_cnt [2] = '{0, 0};
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .send  (send_v[0]),
    .data  (data_v[0][7:0]),
`ifdef UART_TX_CTS_EN
    .cts_n (1'b0),
`endif
    .ready (ready_v[0]),
    .dout  (dout_v[0]),
    .done  (done_v[0])
  );

  uart_tx_frame #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .send  (send_v[1]),
    .data  (data_v[1][6:0]),
`ifdef UART_TX_CTS_EN
    .cts_n (1'b0),
`endif
    .ready (ready_v[1]),
    .dout  (dout_v[1]),
    .done  (done_v[1])
  );

  task automatic check(input string nm, input int i, input logic [2:0] act, input logic [2:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d t=%0t {dout,done,ready} got %b expected %b", nm, i, $time, act, exp);
    end
  endtask

  // Reference model: the frame is a list of line levels, each held for cd cycles.
  task automatic push_frame(input int i, input logic [8:0] d);
    logic bits [$];
    logic p;
    exp_t e;
    int   len;
    bits.push_back(1'b0);
    p = 1'b0;
    for (int k = 0; k < db[i]; k++) begin
      bits.push_back(d[k]);
      p = p ^ d[k];
    end
    if (pa[i] != 0) bits.push_back((pa[i] == 2) ? ~p : p);
    for (int k = 0; k < sb[i]; k++) bits.push_back(1'b1);
    len = bits.size() * cd[i];
    for (int c = 0; c < len; c++) begin
      e.dout  = bits[c / cd[i]];
      e.done  = (c == len - 1);
      e.ready = (c == len - 1);
      q[i].push_back(e);
    end
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (send_v[i] && cur_ready[i]) begin
          push_frame(i, data_v[i]);
          acc_cnt[i]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      if (!rst_n || q[i].size() == 0) e = '{dout: 1'b1, done: 1'b0, ready: 1'b1};
      else                            e = q[i].pop_front();
      cur_ready[i] = e.ready;
      check("cycle", i, {dout_v[i], done_v[i], ready_v[i]}, e);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((q[0].size() != 0 || q[1].size() != 0) && n < limit) begin
      step();
      n++;
    end
    if (n >= limit) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout after %0d cycles, queue sizes %0d/%0d required 0/0",
               n, q[0].size(), q[1].size());
    end
  endtask

  task automatic wait_accept(input int i, input int limit);
    int start, n;
    start = acc_cnt[i];
    n = 0;
    while (acc_cnt[i] == start && n < limit) begin
      step();
      n++;
    end
    if (acc_cnt[i] == start) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout dut%0d got no accept within %0d cycles", i, limit);
    end
  endtask

  initial begin
    data_v[0] = '0;
    data_v[1] = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Single frames: 8'h6C on the 8N1 instance, 7'h55 on the 7O2 instance.
    data_v[0] = 9'h06C;
    data_v[1] = 9'h055;
    send_v    = 2'b11;
    step();
    send_v    = 2'b00;
    wait_idle(400);
    repeat (3) step();

    // Back-to-back with send held high; payload changes right after each accept.
    data_v[0] = 9'h0A5;
    send_v[0] = 1'b1;
    wait_accept(0, 10);
    data_v[0] = 9'h03C;
    wait_accept(0, 400);
    data_v[0] = 9'h1FF;
    send_v[0] = 1'b0;
    wait_idle(400);

    // Random traffic; data toggles every cycle to show it is ignored while busy.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        send_v[i] = ($urandom_range(0, 3) != 0);
        data_v[i] = 9'($urandom);
      end
      step();
    end
    send_v = 2'b00;
    wait_idle(400);

    // Reset during the third data bit of the 8N1 instance.
    data_v[0] = 9'h06C;
    send_v[0] = 1'b1;
    step();
    send_v[0] = 1'b0;
    repeat (52) step();
    rst_n = 1'b0;
    q[0].delete();
    q[1].delete();
    cur_ready[0] = 1'b1;
    cur_ready[1] = 1'b1;
    #1;
    for (int i = 0; i < 2; i++)
      check("async_reset", i, {dout_v[i], done_v[i], ready_v[i]}, 3'b101);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    data_v[0] = 9'h0C3;
    data_v[1] = 9'h07F;
    send_v    = 2'b11;
    step();
    send_v    = 2'b00;
    wait_idle(400);
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Parametrised UART transmitter; successor to the fixed 8N1 tx block.
- Configurable clocks-per-bit, data width, parity mode and stop-bit count.
- Explicit ready/valid handshake, back-to-back frames, frame-done pulse.
- Sits between the host-side byte source and the serial output pin.

Parameters:
- CLK_DIV, 16, clk cycles per serial bit; legal range >= 2.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- send  input  1  valid; request to transmit `data`.
- data  input  DATA_BITS  frame payload; sampled only on accept.
- ready  output  1  block can accept a new frame this cycle.
- dout  output  1  serial line; idle high.
- done  output  1  one-cycle pulse when the last stop bit completes.

Behaviour:
- Reset values while rst_n low (asynchronous, immediate):
  - dout=1, ready=1, done=0, state=IDLE.
  - Bit counter and divider counter cleared.
- Reset mid-frame: frame aborted; dout forced high at once; no done pulse.
- Accept: rising edge with send=1 and ready=1.
  - data is latched into the shift register.
  - ready=0 from the next cycle.
- Cycle after accept: dout=0 (start bit); divider counts 0..CLK_DIV-1 per bit.
- States and transitions:
  - IDLE -> START on accept.
  - START -> DATA after CLK_DIV cycles.
  - DATA: DATA_BITS bits, LSB first, each CLK_DIV cycles.
  - DATA -> PARITY if PARITY != 0, else DATA -> STOP.
  - PARITY: one bit = XOR of latched data (even), inverted (odd).
  - STOP: dout=1 for STOP_BITS*CLK_DIV cycles.
  - STOP -> IDLE.
- Frame length: CLK_DIV*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles, start-bit edge to ready.
- Frame end (final stop-bit cycle):
  - done=1 for exactly one cycle.
  - ready=1 in the same cycle.
- Back-to-back: send=1 during the done cycle is accepted that cycle.
  - Next start bit follows with no idle gap.
- While ready=0: send and data are ignored; data changes never affect the frame in flight.
- dout is registered; no combinational path from inputs to dout.
- Illegal parameter values: elaboration-time $error.

Optional Feature:
- Macro: UART_TX_CTS_EN.
- Defined:
  - Adds input cts_n (1 bit, active-low clear-to-send), synchronised by two flops.
  - In IDLE, ready = ~cts_n_sync; send while cts deasserted is not accepted.
  - A frame already started always completes regardless of cts_n.
  - Synchroniser flops reset to 1 (not clear).
- Undefined:
  - Port absent.
  - ready depends only on state.

Test Plan:
- Default params (8N1, CLK_DIV=16), send=1 for one cycle with data=8'h6C -> start bit low for 16 cycles, then data bits 0,0,1,1,0,1,1,0 at 16 cycles each, then stop high for 16 cycles; done pulses at cycle 160 after the start edge; ready low for 160 cycles.
- PARITY=1, data=8'h6C -> parity bit 0; PARITY=2, same data -> parity bit 1; PARITY=1, data=8'hFF -> parity bit 0; frame length 176 cycles.
- send held high across two frames, data=8'hA5 then 8'h3C -> second start bit begins on the cycle after done with no extra idle; both bytes serialised correctly.
- DATA_BITS=7, STOP_BITS=2, CLK_DIV=4, data=7'h55 -> 1+7+2 bits at 4 cycles each = 40 cycles; line high for the final 8 cycles.
- rst_n pulsed low during the 3rd data bit -> dout high in the same cycle, ready=1, no done pulse; a new send after release produces a clean full frame.
- UART_TX_CTS_EN defined, cts_n=1, send=1 -> no accept and dout stays high; cts_n->0 -> accept within 3 cycles; cts_n->1 mid-frame -> frame completes normally.
